req_arbiter: RTL and testbench

- Two-master arbiter for the system request bus (req/write/read channels) that feeds `req_decoder`.
- Master 0 is the CPU bus interface. Master 1 is a new DMA requester, e.g. the VGA framebuffer fetcher.
- Grants one whole transaction at a time: request handshake, then all write or read beats. Only then does it re-arbitrate, so bursts are never interleaved.
- Sits between `cpuif`/DMA and `req_decoder`, in the `sys_clk` domain.

---
 rtl/req_arbiter_pkg.sv | 15 +
 rtl/rr_pick2.sv | 32 +++
 rtl/req_arbiter.sv | 124 ++++++++++++
 tb/tb_req_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_arbiter_pkg.sv
// Shared constants for the two-master system request bus arbiter.
package req_arbiter_pkg;
  // Arbiter FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WDATA = 2'd2;
  localparam logic [1:0] ST_RDATA = 2'd3;

  // Beat counter width (len = beats-1, 1..8 beats)
  localparam int LEN_W = 3;

  // Master indices
  localparam int M_CPU = 0;
  localparam int M_DMA = 1;
endpackage

// File: rtl/rr_pick2.sv
// 2-way winner picker for the request arbiter.
// Default: round-robin, the master that did not own the bus last wins a tie.
// REQ_ARB_FIXED_PRIO_EN: the DMA master always wins a tie; last is ignored.
module rr_pick2
  import req_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

`ifdef REQ_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  // DMA (display refresh) beats the CPU whenever both ask
  always_comb begin
    win = req;
    if (req[M_DMA]) begin
      win        = '0;
      win[M_DMA] = 1'b1;
    end
  end
`else
  // On a tie hand the bus to whoever did not have it last
  always_comb begin
    win = req;
    if (&req) win = last ? 2'b01 : 2'b10;
  end
`endif

endmodule

// File: rtl/req_arbiter.sv
// Two-master arbiter (CPU = master 0, DMA = master 1) in front of req_decoder.
// Grants a whole transaction (request + all data beats) before re-arbitrating,
// so bursts from the two masters never interleave.
// Optional build macro: REQ_ARB_FIXED_PRIO_EN (DMA wins every tie).
module req_arbiter
  import req_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            m_req_valid,
  output logic [1:0]            m_req_ready,
  input  logic [2*ADDR_W-1:0]   m_req_addr,
  input  logic [2*LEN_W-1:0]    m_req_len,
  input  logic [2*MASK_W-1:0]   m_req_mask,
  input  logic [1:0]            m_req_we,
  input  logic [1:0]            m_write_valid,
  input  logic [2*DATA_W-1:0]   m_write_data,
  output logic [1:0]            m_read_valid,
  output logic [DATA_W-1:0]     m_read_data,
  input  logic [1:0]            m_read_ack,
  output logic                  s_req_valid,
  input  logic                  s_req_ready,
  output logic [ADDR_W-1:0]     s_req_addr,
  output logic [LEN_W-1:0]      s_req_len,
  output logic [MASK_W-1:0]     s_req_mask,
  output logic                  s_req_we,
  output logic                  s_write_valid,
  output logic [DATA_W-1:0]     s_write_data,
  input  logic                  s_read_valid,
  input  logic [DATA_W-1:0]     s_read_data,
  output logic                  s_read_ack,
  output logic [1:0]            grant,
  output logic                  busy
);

  logic [1:0]       state;
  logic [1:0]       grant_q;
  logic [LEN_W-1:0] cnt;
  logic             last;
  logic [1:0]       win;
  logic [LEN_W-1:0] win_len;
  logic             g;
  logic             beat;

  rr_pick2 u_pick (
    .req  (m_req_valid),
    .last (last),
    .win  (win)
  );

  // Grant is one-hot, so the DMA bit alone selects the owner
  assign g       = grant_q[M_DMA];
  assign win_len = win[M_DMA] ? m_req_len[2*LEN_W-1:LEN_W] : m_req_len[LEN_W-1:0];

  // Request channel: straight mux of the owner, valid/ready only in REQ
  assign s_req_valid = (state == ST_REQ) && m_req_valid[g];
  assign s_req_addr  = g ? m_req_addr[2*ADDR_W-1:ADDR_W] : m_req_addr[ADDR_W-1:0];
  assign s_req_len   = g ? m_req_len[2*LEN_W-1:LEN_W]    : m_req_len[LEN_W-1:0];
  assign s_req_mask  = g ? m_req_mask[2*MASK_W-1:MASK_W] : m_req_mask[MASK_W-1:0];
  assign s_req_we    = m_req_we[g];
  assign m_req_ready = (state == ST_REQ) ? (grant_q & {2{s_req_ready}}) : 2'b00;

  // Write channel: the slave has no back-pressure, every valid cycle is a beat
  assign s_write_valid = (state == ST_WDATA) && m_write_valid[g];
  assign s_write_data  = g ? m_write_data[2*DATA_W-1:DATA_W] : m_write_data[DATA_W-1:0];

  // Read channel: data is broadcast, valid/ack only for the owner
  assign m_read_data  = s_read_data;
  assign m_read_valid = (state == ST_RDATA) ? (grant_q & {2{s_read_valid}}) : 2'b00;
  assign s_read_ack   = (state == ST_RDATA) && m_read_ack[g];

  assign beat  = s_write_valid || (s_read_valid && s_read_ack);
  assign grant = grant_q;
  assign busy  = (state != ST_IDLE);

  // Transaction FSM: arbitrate, pass the request, count data beats
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant_q <= 2'b00;
      cnt     <= '0;
      last    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|m_req_valid) begin
            grant_q <= win;
            cnt     <= win_len;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Owner withdrew before acceptance: give the bus up
          if (!m_req_valid[g]) begin
            state   <= ST_IDLE;
            grant_q <= 2'b00;
          end else if (s_req_ready) begin
            state <= m_req_we[g] ? ST_WDATA : ST_RDATA;
          end
        end
        ST_WDATA, ST_RDATA: begin
          if (beat) begin
            if (cnt == '0) begin
              state   <= ST_IDLE;
              grant_q <= 2'b00;
              last    <= g;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter.sv
// Self-checking bench for req_arbiter: transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, then
// randomized masters and slave.
module tb_req_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
`ifdef REQ_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      m_req_valid = '0;
  logic [1:0]      m_req_ready;
  logic [2*AW-1:0] m_req_addr = '0;
  logic [5:0]      m_req_len = '0;
  logic [2*MW-1:0] m_req_mask = '0;
  logic [1:0]      m_req_we = '0;
  logic [1:0]      m_write_valid = '0;
  logic [2*DW-1:0] m_write_data = '0;
  logic [1:0]      m_read_valid;
  logic [DW-1:0]   m_read_data;
  logic [1:0]      m_read_ack = '0;
  logic            s_req_valid;
  logic            s_req_ready = 1'b0;
  logic [AW-1:0]   s_req_addr;
  logic [2:0]      s_req_len;
  logic [MW-1:0]   s_req_mask;
  logic            s_req_we;
  logic            s_write_valid;
  logic [DW-1:0]   s_write_data;
  logic            s_read_valid = 1'b0;
  logic [DW-1:0]   s_read_data = '0;
  logic            s_read_ack;
  logic [1:0]      grant;
  logic            busy;

  int errors = 0;
  int checks = 0;

  req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
    .clk(clk), .rst(rst),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_addr(m_req_addr), .m_req_len(m_req_len),
    .m_req_mask(m_req_mask), .m_req_we(m_req_we),
    .m_write_valid(m_write_valid), .m_write_data(m_write_data),
    .m_read_valid(m_read_valid), .m_read_data(m_read_data),
    .m_read_ack(m_read_ack),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_addr(s_req_addr), .s_req_len(s_req_len),
    .s_req_mask(s_req_mask), .s_req_we(s_req_we),
    .s_write_valid(s_write_valid), .s_write_data(s_write_data),
    .s_read_valid(s_read_valid), .s_read_data(s_read_data),
    .s_read_ack(s_read_ack),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, whether the request is accepted,
  // direction and beats still owed.
  int owner = -1;
  bit accepted = 0;
  bit is_wr = 0;
  bit last_own = 1;
  int beats_left = 0;

  always @(negedge clk) begin : model
    int gi;
    int pick;
    bit in_req, in_w, in_r, beat;
    logic [1:0] oh;
    gi = (owner < 0) ? 0 : owner;
    oh = (owner < 0) ? 2'b00 : ((gi == 1) ? 2'b10 : 2'b01);
    in_req = (owner >= 0) && !accepted;
    in_w   = (owner >= 0) && accepted && is_wr;
    in_r   = (owner >= 0) && accepted && !is_wr;

    chk("grant", grant, oh);
    chk("busy", busy, owner >= 0);
    chk("s_req_valid", s_req_valid, in_req && m_req_valid[gi]);
    chk("m_req_ready", m_req_ready, (in_req && s_req_ready) ? oh : 2'b00);
    if (in_req) begin
      chk("s_req_addr", s_req_addr, m_req_addr[gi*AW +: AW]);
      chk("s_req_len", s_req_len, m_req_len[gi*3 +: 3]);
      chk("s_req_mask", s_req_mask, m_req_mask[gi*MW +: MW]);
      chk("s_req_we", s_req_we, m_req_we[gi]);
    end
    chk("s_write_valid", s_write_valid, in_w && m_write_valid[gi]);
    if (in_w) chk("s_write_data", s_write_data, m_write_data[gi*DW +: DW]);
    chk("m_read_valid", m_read_valid, (in_r && s_read_valid) ? oh : 2'b00);
    chk("s_read_ack", s_read_ack, in_r && m_read_ack[gi]);
    chk("m_read_data", m_read_data, s_read_data);

    if (rst) begin
      owner = -1; accepted = 0; last_own = 1;
    end else if (owner < 0) begin
      if (m_req_valid != 2'b00) begin
        if (m_req_valid == 2'b11) pick = FIXED ? 1 : (last_own ? 0 : 1);
        else pick = m_req_valid[1] ? 1 : 0;
        owner = pick;
        accepted = 0;
        beats_left = int'(m_req_len[pick*3 +: 3]) + 1;
      end
    end else if (!accepted) begin
      if (!m_req_valid[gi]) owner = -1;
      else if (s_req_ready) begin
        accepted = 1;
        is_wr = m_req_we[gi];
      end
    end else begin
      beat = is_wr ? m_write_valid[gi] : (s_read_valid && m_read_ack[gi]);
      if (beat) begin
        beats_left--;
        if (beats_left == 0) begin
          owner = -1;
          last_own = (gi == 1);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [2:0] l,
                         input logic we);
    m_req_addr[i*AW +: AW] = a;
    m_req_len[i*3 +: 3]    = l;
    m_req_mask[i*MW +: MW] = 4'hF;
    m_req_we[i]            = we;
  endtask

  task automatic do_reset();
    m_req_valid = '0; m_write_valid = '0; m_read_ack = '0;
    s_req_ready = 1'b0; s_read_valid = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  logic [1:0] acc;

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset grant", grant, 2'b00);
    chk("reset busy", busy, 1'b0);

    // Single CPU read, 4 beats
    set_req(0, 32'h0000_1000, 3'd3, 1'b0);
    m_req_valid = 2'b01; s_req_ready = 1'b1;
    cyc(); @(negedge clk);
    chk("t1 grant", grant, 2'b01);
    chk("t1 s_req_addr", s_req_addr, 32'h0000_1000);
    cyc();
    m_req_valid = 2'b00; m_read_ack = 2'b11;
    for (int k = 0; k < 4; k++) begin
      s_read_valid = 1'b1; s_read_data = 32'h11 * (k + 1);
      @(negedge clk);
      chk("t1 m_read_valid", m_read_valid, 2'b01);
      chk("t1 m_read_data", m_read_data, 32'h11 * (k + 1));
      cyc();
    end
    s_read_valid = 1'b0;
    @(negedge clk);
    chk("t1 idle busy", busy, 1'b0);
    chk("t1 idle grant", grant, 2'b00);

`ifndef REQ_ARB_FIXED_PRIO_EN
    // Simultaneous requests: CPU first, DMA right after, then CPU again
    do_reset();
    set_req(0, 32'hA0, 3'd1, 1'b1);
    set_req(1, 32'hA1, 3'd0, 1'b1);
    m_write_data = {32'hD0, 32'hC0};
    m_write_valid = 2'b11; m_req_valid = 2'b11; s_req_ready = 1'b1;
    cyc(); @(negedge clk);
    chk("t2 first grant", grant, 2'b01);
    cyc(); m_req_valid = 2'b10;
    @(negedge clk);
    chk("t2 cpu wdata", s_write_data, 32'hC0);
    cyc(); cyc(); @(negedge clk);
    chk("t2 gap grant", grant, 2'b00);
    cyc(); @(negedge clk);
    chk("t2 second grant", grant, 2'b10);
    cyc(); m_req_valid = 2'b00;
    cyc(); m_req_valid = 2'b11;
    cyc(); @(negedge clk);
    chk("t2 third grant", grant, 2'b01);
    m_req_valid = 2'b00;
    cyc(); @(negedge clk);
    chk("t2 withdraw busy", busy, 1'b0);
`endif

    // DMA write len=0 while the CPU also asks and drives write_valid
    do_reset();
    set_req(1, 32'h8000_0010, 3'd0, 1'b1);
    set_req(0, 32'h0000_0020, 3'd0, 1'b0);
    m_req_valid = 2'b10; s_req_ready = 1'b1;
    cyc(); @(negedge clk);
    chk("t3 dma grant", grant, 2'b10);
    chk("t3 dma addr", s_req_addr, 32'h8000_0010);
    cyc();
    m_req_valid = 2'b01; m_write_valid = 2'b11;
    m_write_data = {32'h0000_0D1A, 32'h0000_0BAD};
    @(negedge clk);
    chk("t3 s_write_valid", s_write_valid, 1'b1);
    chk("t3 s_write_data", s_write_data, 32'h0000_0D1A);
    cyc(); @(negedge clk);
    chk("t3 single beat", s_write_valid, 1'b0);
    cyc(); @(negedge clk);
    chk("t3 cpu next", grant, 2'b01);

    // s_req_ready held low for 5 cycles in REQ
    do_reset();
    set_req(0, 32'h0000_1234, 3'd0, 1'b0);
    m_write_valid = 2'b00; m_req_valid = 2'b01; s_req_ready = 1'b0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4 hold valid", s_req_valid, 1'b1);
      chk("t4 hold addr", s_req_addr, 32'h0000_1234);
      chk("t4 hold ready", m_req_ready, 2'b00);
      cyc();
    end
    s_req_ready = 1'b1;
    @(negedge clk);
    chk("t4 ready 6th", m_req_ready, 2'b01);
    cyc(); m_req_valid = 2'b00;

    // Reset during RDATA beat 2 of 4
    do_reset();
    set_req(0, 32'h0000_4000, 3'd3, 1'b0);
    m_req_valid = 2'b01; s_req_ready = 1'b1;
    cyc(); cyc();
    m_req_valid = 2'b00; m_read_ack = 2'b01; s_read_valid = 1'b1;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; s_read_valid = 1'b0; m_read_ack = 2'b00;
    @(negedge clk);
    chk("t5 grant", grant, 2'b00);
    chk("t5 busy", busy, 1'b0);
    chk("t5 m_read_valid", m_read_valid, 2'b00);
    m_req_valid = 2'b01;
    cyc(); @(negedge clk);
    chk("t5 regrant", grant, 2'b01);
    m_req_valid = 2'b00;
    cyc();

`ifdef REQ_ARB_FIXED_PRIO_EN
    // Both masters request continuously: DMA wins every time
    do_reset();
    set_req(0, 32'h10, 3'd0, 1'b0);
    set_req(1, 32'h20, 3'd0, 1'b0);
    m_req_valid = 2'b11; s_req_ready = 1'b1; s_read_valid = 1'b1; m_read_ack = 2'b11;
    for (int k = 0; k < 4; k++) begin
      cyc(); @(negedge clk);
      chk("fixed grant", grant, 2'b10);
      cyc(); cyc();
    end
`endif

    // Random masters and slave against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc = m_req_valid & m_req_ready;
      cyc();
      for (int i = 0; i < 2; i++) begin
        if (m_req_valid[i] && (acc[i] || $urandom_range(0, 99) == 0)) begin
          m_req_valid[i] = 1'b0;
        end else if (!m_req_valid[i] && $urandom_range(0, 3) == 0) begin
          set_req(i, $urandom, 3'($urandom_range(0, 7)), 1'($urandom));
          m_req_mask[i*MW +: MW] = 4'($urandom);
          m_req_valid[i] = 1'b1;
        end
      end
      m_write_valid = 2'($urandom);
      m_write_data  = {$urandom, $urandom};
      m_read_ack    = 2'($urandom);
      s_req_ready   = ($urandom_range(0, 2) != 0);
      s_read_valid  = 1'($urandom);
      s_read_data   = $urandom;
      rst           = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
